// File: rtl/m_wb_stage_queue_pkg.sv
// M->WB payload layout and default queue depth, shared by the M and WB stages.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif
`ifndef M_WB_Q_DEPTH
`define M_WB_Q_DEPTH 2
`endif

package m_wb_stage_queue_pkg;

    localparam int WORD_SIZE       = `WORD_SIZE;
    localparam int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ;
    localparam int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH;
    localparam int M_WB_Q_DEPTH    = `M_WB_Q_DEPTH;

    typedef struct packed {
        logic [INSTR_TYPE_SZ-1:0]   instruction_type;
        logic [WORD_SIZE-1:0]       pc;
        logic                       exception;
        logic [WORD_SIZE-1:0]       virtual_addr_exception;
        logic [WORD_SIZE-1:0]       aluResult;
        logic [ROB_ENTRY_WIDTH-1:0] rob_id;
    } m_wb_payload_t;

endpackage

// File: rtl/m_wb_stage_queue_if.sv
// Handshake and payload bundle between the M stage, the queue and WB.
interface m_wb_stage_queue_if
    import m_wb_stage_queue_pkg::*;
#(
    parameter int DEPTH = M_WB_Q_DEPTH
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [INSTR_TYPE_SZ-1:0]   instruction_type;
    logic [WORD_SIZE-1:0]       pc;
    logic                       exception;
    logic [WORD_SIZE-1:0]       virtual_addr_exception;
    logic [WORD_SIZE-1:0]       aluResult;
    logic [ROB_ENTRY_WIDTH-1:0] rob_id;

    logic                       out_valid;
    logic                       out_ready;
    logic [INSTR_TYPE_SZ-1:0]   instruction_type_out;
    logic [WORD_SIZE-1:0]       pc_out;
    logic                       exception_out;
    logic [WORD_SIZE-1:0]       virtual_addr_exception_out;
    logic [WORD_SIZE-1:0]       aluResult_out;
    logic [ROB_ENTRY_WIDTH-1:0] rob_id_out;
    logic [CNT_W-1:0]           count;

    modport slave (
        input  flush, in_valid, instruction_type, pc, exception,
               virtual_addr_exception, aluResult, rob_id, out_ready,
        output in_ready, out_valid, instruction_type_out, pc_out, exception_out,
               virtual_addr_exception_out, aluResult_out, rob_id_out, count
    );

    modport master (
        output flush, in_valid, instruction_type, pc, exception,
               virtual_addr_exception, aluResult, rob_id, out_ready,
        input  in_ready, out_valid, instruction_type_out, pc_out, exception_out,
               virtual_addr_exception_out, aluResult_out, rob_id_out, count
    );
endinterface

// File: rtl/defines.sv
// Shared pipeline widths for the M and WB stages.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif
`ifndef M_WB_Q_DEPTH
`define M_WB_Q_DEPTH 2
`endif

// File: rtl/sync_fifo_ptr_ctrl.sv
// Payload-agnostic read/write pointer, occupancy and flush bookkeeping for a
// power-of-two synchronous FIFO; ready/valid are registered from occupancy.
module sync_fifo_ptr_ctrl #(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             push,
    output logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
        // ready/valid are stored alongside count so neither output has a
        // combinational path from out_ready.
        in_ready_d  = (count_d != CNT_W'(DEPTH));
        out_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign wr_ptr    = wr_ptr_q;
    assign rd_ptr    = rd_ptr_q;
    assign count     = count_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
endmodule

// File: rtl/m_wb_stage_queue.sv
// DEPTH-entry in-order queue between the memory stage and writeback, with
// flush and occupancy; the head payload is held in a register.
module m_wb_stage_queue
    import m_wb_stage_queue_pkg::*;
#(
    parameter  int DEPTH = M_WB_Q_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    m_wb_stage_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             push, pop;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CNT_W-1:0] count;

    m_wb_payload_t    in_payload;
    m_wb_payload_t    mem_q [DEPTH];
    m_wb_payload_t    head_q, head_d;

    sync_fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .push      (push),
        .pop       (pop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    assign in_payload = '{
        instruction_type:       bus.instruction_type,
        pc:                     bus.pc,
        exception:              bus.exception,
        virtual_addr_exception: bus.virtual_addr_exception,
        aluResult:              bus.aluResult,
        rob_id:                 bus.rob_id
    };

    assign rd_next = rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (push && !bus.flush) mem_q[wr_ptr] <= in_payload;
    end

    // Head register tracks the entry that will sit at rd_ptr after this edge;
    // an entry written this cycle into an otherwise-empty slot comes straight
    // from the input bus.
    always_comb begin
        head_d = head_q;
        if (!bus.flush) begin
            if (pop) begin
                if (count == CNT_W'(1)) begin
                    if (push) head_d = in_payload;
                end else begin
                    head_d = mem_q[rd_next];
                end
            end else if (count == '0 && push) begin
                head_d = in_payload;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) head_q <= '0;
        else        head_q <= head_d;
    end

    assign bus.instruction_type_out       = head_q.instruction_type;
    assign bus.pc_out                     = head_q.pc;
    assign bus.exception_out              = head_q.exception;
    assign bus.virtual_addr_exception_out = head_q.virtual_addr_exception;
    assign bus.aluResult_out              = head_q.aluResult;
    assign bus.rob_id_out                 = head_q.rob_id;
    assign bus.count                      = count;
endmodule

// File: tb/tb_m_wb_stage_queue.sv
// Scoreboard bench for m_wb_stage_queue at DEPTH=2 and DEPTH=4.
module tb_m_wb_stage_queue;
    import m_wb_stage_queue_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    m_wb_payload_t mq [2][$];
    int            popped [2];

    m_wb_stage_queue_if #(.DEPTH(2)) if_a ();
    m_wb_stage_queue_if #(.DEPTH(4)) if_b ();

    m_wb_stage_queue #(.DEPTH(2)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    m_wb_stage_queue #(.DEPTH(4)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

    m_wb_payload_t head_a, head_b, in_a, in_b;
    assign head_a = {if_a.instruction_type_out, if_a.pc_out, if_a.exception_out,
                     if_a.virtual_addr_exception_out, if_a.aluResult_out, if_a.rob_id_out};
    assign head_b = {if_b.instruction_type_out, if_b.pc_out, if_b.exception_out,
                     if_b.virtual_addr_exception_out, if_b.aluResult_out, if_b.rob_id_out};
    assign in_a   = {if_a.instruction_type, if_a.pc, if_a.exception,
                     if_a.virtual_addr_exception, if_a.aluResult, if_a.rob_id};
    assign in_b   = {if_b.instruction_type, if_b.pc, if_b.exception,
                     if_b.virtual_addr_exception, if_b.aluResult, if_b.rob_id};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_pl(input string nm, input m_wb_payload_t act, input m_wb_payload_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got rob=%0h pc=%0h exc=%0b got_all=%0h expected rob=%0h pc=%0h exc=%0b all=%0h at %0t",
                     nm, act.rob_id, act.pc, act.exception, act, exp.rob_id, exp.pc, exp.exception, exp, $time);
        end
    endtask

    function automatic m_wb_payload_t mk(input logic [ROB_ENTRY_WIDTH-1:0] rob,
                                         input logic [WORD_SIZE-1:0] pcv);
        m_wb_payload_t p;
        p = '0;
        p.instruction_type = rob[INSTR_TYPE_SZ-1:0];
        p.pc               = pcv;
        p.aluResult        = pcv + 32'h0000_1000;
        p.rob_id           = rob;
        return p;
    endfunction

    // Reference model: a plain FIFO of payloads updated from the observed
    // handshake inputs, checked against the DUT once per cycle.
    task automatic mon(input int w, input int depth, input logic rst, input logic fl,
                       input logic iv, input logic ordy, input logic ov, input logic ir,
                       input int cnt, input m_wb_payload_t head, input m_wb_payload_t inp);
        string pfx;
        int    sz;
        pfx = (w == 0) ? "A" : "B";
        if (!rst) begin
            mq[w].delete();
            chk({pfx, " reset out_valid"}, 64'(ov), 64'd0);
            chk({pfx, " reset in_ready"},  64'(ir), 64'd1);
            chk({pfx, " reset count"},     64'(cnt), 64'd0);
            chk_pl({pfx, " reset outs"},   head, '0);
            return;
        end
        sz = mq[w].size();
        chk({pfx, " count"},     64'(cnt), 64'(sz));
        chk({pfx, " out_valid"}, 64'(ov),  64'(sz != 0));
        chk({pfx, " in_ready"},  64'(ir),  64'(sz != depth));
        chk({pfx, " count<=depth"}, 64'(cnt <= depth), 64'd1);
        if (sz > 0) chk_pl({pfx, " head"}, head, mq[w][0]);
        if (fl) begin
            mq[w].delete();
        end else begin
            if (sz > 0 && ordy) begin
                void'(mq[w].pop_front());
                popped[w]++;
            end
            if (iv && sz < depth) mq[w].push_back(inp);
        end
    endtask

    always @(negedge clk) begin
        mon(0, 2, reset, if_a.flush, if_a.in_valid, if_a.out_ready, if_a.out_valid,
            if_a.in_ready, int'(if_a.count), head_a, in_a);
        mon(1, 4, reset, if_b.flush, if_b.in_valid, if_b.out_ready, if_b.out_valid,
            if_b.in_ready, int'(if_b.count), head_b, in_b);
    end

    task automatic set_a(input logic iv, input logic ordy, input logic fl, input m_wb_payload_t p);
        if_a.in_valid               = iv;
        if_a.out_ready              = ordy;
        if_a.flush                  = fl;
        if_a.instruction_type       = p.instruction_type;
        if_a.pc                     = p.pc;
        if_a.exception              = p.exception;
        if_a.virtual_addr_exception = p.virtual_addr_exception;
        if_a.aluResult              = p.aluResult;
        if_a.rob_id                 = p.rob_id;
    endtask

    task automatic set_b(input logic iv, input logic ordy, input m_wb_payload_t p);
        if_b.in_valid               = iv;
        if_b.out_ready              = ordy;
        if_b.flush                  = 1'b0;
        if_b.instruction_type       = p.instruction_type;
        if_b.pc                     = p.pc;
        if_b.exception              = p.exception;
        if_b.virtual_addr_exception = p.virtual_addr_exception;
        if_b.aluResult              = p.aluResult;
        if_b.rob_id                 = p.rob_id;
    endtask

    task automatic cyc_a(input logic iv, input logic ordy, input logic fl, input m_wb_payload_t p);
        set_a(iv, ordy, fl, p);
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_wb_payload_t p;
        logic [31:0]   r0, r1, r2;
        int            id, cycles;
        logic          tog, acc;

        popped[0] = 0;
        popped[1] = 0;
        set_a(1'b1, 1'b0, 1'b0, mk(6'd3, 32'h100));
        set_b(1'b0, 1'b0, '0);

        repeat (3) @(posedge clk);
        #1;
        chk("A held reset count",     64'(if_a.count), 64'd0);
        chk("A held reset out_valid", 64'(if_a.out_valid), 64'd0);
        chk("A held reset in_ready",  64'(if_a.in_ready), 64'd1);
        chk_pl("A held reset outs",   head_a, '0);
        reset = 1'b1;

        @(posedge clk);
        #1;
        set_a(1'b0, 1'b0, 1'b0, '0);
        chk("first push out_valid", 64'(if_a.out_valid), 64'd1);
        chk("first push pc_out",    64'(if_a.pc_out), 64'h100);
        chk("first push rob_id",    64'(if_a.rob_id_out), 64'd3);
        cyc_a(1'b0, 1'b1, 1'b0, '0);

        cyc_a(1'b1, 1'b0, 1'b0, mk(6'd1, 32'h110));
        cyc_a(1'b1, 1'b0, 1'b0, mk(6'd2, 32'h120));
        chk("fill count",    64'(if_a.count), 64'd2);
        chk("fill in_ready", 64'(if_a.in_ready), 64'd0);
        cyc_a(1'b1, 1'b0, 1'b0, mk(6'd7, 32'h170));
        chk("refused push count", 64'(if_a.count), 64'd2);
        cyc_a(1'b0, 1'b1, 1'b0, '0);
        chk("drain count 1",  64'(if_a.count), 64'd1);
        chk("drain head 2",   64'(if_a.rob_id_out), 64'd2);
        cyc_a(1'b0, 1'b1, 1'b0, '0);
        chk("drain count 0",  64'(if_a.count), 64'd0);

        cyc_a(1'b1, 1'b0, 1'b0, mk(6'd4, 32'h140));
        cyc_a(1'b1, 1'b1, 1'b0, mk(6'd5, 32'h150));
        chk("push+pop count", 64'(if_a.count), 64'd1);
        chk("push+pop head",  64'(if_a.rob_id_out), 64'd5);

        cyc_a(1'b1, 1'b0, 1'b0, mk(6'd8, 32'h180));
        chk("pre-flush count", 64'(if_a.count), 64'd2);
        cyc_a(1'b1, 1'b1, 1'b1, mk(6'd10, 32'h1a0));
        chk("flush count",     64'(if_a.count), 64'd0);
        chk("flush out_valid", 64'(if_a.out_valid), 64'd0);
        chk("flush in_ready",  64'(if_a.in_ready), 64'd1);
        cyc_a(1'b0, 1'b0, 1'b0, '0);
        chk("post-flush out_valid", 64'(if_a.out_valid), 64'd0);

        p = mk(6'd12, 32'h200);
        p.exception = 1'b1;
        p.virtual_addr_exception = 32'hDEAD_BEEF;
        cyc_a(1'b1, 1'b0, 1'b0, p);
        set_a(1'b0, 1'b0, 1'b0, '0);
        chk("exception_out",  64'(if_a.exception_out), 64'd1);
        chk("vaddr_exc_out",  64'(if_a.virtual_addr_exception_out), 64'hDEAD_BEEF);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async reset out_valid", 64'(if_a.out_valid), 64'd0);
        chk("async reset count",     64'(if_a.count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // DEPTH=4 stream with alternating out_ready.
        id = 0;
        tog = 1'b1;
        cycles = 0;
        while (popped[1] < 10 && cycles < 200) begin
            set_b(id < 10, tog, mk(id[ROB_ENTRY_WIDTH-1:0], 32'h400 + 32'(id) * 32'd4));
            @(negedge clk);
            acc = if_b.in_valid && if_b.in_ready;
            @(posedge clk);
            #1;
            if (acc) id++;
            tog = ~tog;
            cycles++;
        end
        set_b(1'b0, 1'b0, '0);
        chk("B stream popped", 64'(popped[1]), 64'd10);
        chk("B stream empty",  64'(if_b.count), 64'd0);

        repeat (400) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom;
            p = mk(r0[ROB_ENTRY_WIDTH-1:0], r1);
            p.exception = r0[31];
            p.virtual_addr_exception = r2;
            set_a(r0[8:7] != 2'b00, r0[9], r0[13:10] == 4'd0, p);
            p = mk(r1[ROB_ENTRY_WIDTH-1:0], r2);
            set_b(r1[30], r1[29], p);
            @(posedge clk);
            #1;
        end
        set_a(1'b0, 1'b1, 1'b0, '0);
        set_b(1'b0, 1'b1, '0);
        repeat (6) @(posedge clk);
        #1;
        chk("A final empty", 64'(if_a.count), 64'd0);
        chk("B final empty", 64'(if_b.count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/m_wb_stage_queue.md
Name: m_wb_stage_queue

Overview:
Parametrised successor to the fixed M->WB pipeline register: a DEPTH-entry in-order queue between the memory stage and writeback/ROB completion. It has a valid/ready handshake on both sides, so a stalled writeback port no longer drops or overwrites results. It also provides a synchronous flush for pipeline squash and an occupancy count for stall logic.

Parameters:
WORD_SIZE, `WORD_SIZE, width of pc, aluResult, virtual_addr_exception
INSTR_TYPE_SZ, `INSTR_TYPE_SZ, width of instruction_type
ROB_ENTRY_WIDTH, `ROB_ENTRY_WIDTH, width of rob_id
DEPTH, 2, number of queue entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of count output (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous squash of all entries
in_valid  input  1  M stage presents an entry
in_ready  output  1  queue accepts an entry this cycle
instruction_type  input  INSTR_TYPE_SZ  payload
pc  input  WORD_SIZE  payload
exception  input  1  payload
virtual_addr_exception  input  WORD_SIZE  payload
aluResult  input  WORD_SIZE  payload
rob_id  input  ROB_ENTRY_WIDTH  payload
out_valid  output  1  head entry valid
out_ready  input  1  WB consumes head this cycle
instruction_type_out, pc_out, exception_out, virtual_addr_exception_out, aluResult_out, rob_id_out  output  as inputs  head payload
count  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (reset==0, asynchronous): wr_ptr=rd_ptr=0, count=0, out_valid=0, in_ready=1, all *_out=0. Storage array contents are don't-care.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational dependence on out_ready. A push to a full queue is refused even if a pop happens in the same cycle.
- out_valid = (count != 0). The *_out ports are driven from the head entry (storage read at rd_ptr).
- When out_valid==0, the *_out ports hold the last popped payload (or 0 after reset). The bench must not check them in that state.
- Latency: an entry pushed at edge N is visible on *_out with out_valid=1 after edge N, if the queue was empty. There is no same-cycle bypass.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal when 0 < count < DEPTH, and also at count==DEPTH? No: at count==DEPTH the push is refused.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Ordering: strictly FIFO; rob_id order out equals order in.
- flush (synchronous, sampled at rising edge): count=0, rd_ptr=wr_ptr=0, out_valid=0 next cycle.
  - flush has priority over push and pop in the same cycle. The incoming entry is discarded and the pop has no effect on state.
  - The WB side must treat a head presented in the flush cycle as squashed; the upstream flush source guarantees this.
- Payload is opaque: the exception and virtual_addr_exception fields are stored and forwarded unchanged. An exception entry is queued like any other.
- Asserting reset mid-operation discards all entries immediately, regardless of clk.
- count is always consistent with out_valid/in_ready: out_valid==(count!=0) and in_ready==(count!=DEPTH).
- No X on control outputs at any time after reset release.

Decomposition:
- defines.sv keeps WORD_SIZE, INSTR_TYPE_SZ, ROB_ENTRY_WIDTH.
- Add an M_WB payload packed-struct typedef and a default `M_WB_Q_DEPTH constant to the shared package, so the M stage and WB stage share the field layout.
- One natural sub-module: sync_fifo_ptr_ctrl (pointer/count/flush bookkeeping, payload-agnostic). The top holds the storage array, packs/unpacks the struct and drives the *_out ports.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1, all *_out=0; after release the first push (pc=0x100, rob_id=3) appears on pc_out/rob_id_out with out_valid=1 one edge later.
- Fill/backpressure: out_ready=0, push DEPTH=2 entries (rob_id 1,2) -> count=2, in_ready=0; a third in_valid is not accepted; then out_ready=1 pops rob_id 1 then 2 in order, count 2->1->0.
- Simultaneous push/pop at count=1: push rob_id 5 while popping rob_id 4 -> count stays 1, head becomes rob_id 5 next cycle.
- Flush priority: count=2, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; the flushed incoming entry never appears.
- Wrap-around with DEPTH=4: stream 10 entries, rob_id 0..9, with out_ready toggling 1,0,1,0 -> output order 0..9, no loss or duplication, count never exceeds 4.
- Exception payload plus async reset: push exception=1, virtual_addr_exception=0xDEAD_BEEF, which forwards unchanged; then assert reset between clock edges -> out_valid drops to 0 immediately, without waiting for clk.
